result_bus_arbiter: RTL and testbench
=====================================

# result_bus_arbiter

Collects completed results from the execution units and broadcasts them, one per cycle, on the shared operand-update bus that every reservation station snoops. Each unit hands over an (rs_id, value) pair through a ready-valid interface into a small per-unit FIFO. A round-robin arbiter drains the FIFOs onto a registered, valid-only broadcast port (operand_valid / update_op_rs_id / update_op_value). It sits between the unit outputs and the reservation-station update inputs.

## Interface
- UNITS, 4, number of result producers (≥2)
- RS_ID_WIDTH, 5, tag width; matches reservation stations
- BUFFER_DEPTH, 2, entries per unit FIFO (power of two, ≥2)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- result_valid  in  [0:UNITS-1]  unit i offers a result
- result_ready  out  [0:UNITS-1]  unit i FIFO can accept
- result_rs_id  in  UNITS x RS_ID_WIDTH  tag of producing RS entry
- result_value  in  UNITS x 32  result data (bit 0 = MSB)
- operand_valid  out  1  broadcast valid, one-cycle pulse per result
- update_op_rs_id  out  RS_ID_WIDTH  broadcast tag
- update_op_value  out  32  broadcast value

## Operation
- Handshake per unit: transfer when result_valid[i] && result_ready[i] at a rising edge; write into FIFO i.
- result_ready[i] = (count[i] != BUFFER_DEPTH), derived from registered count only. A full FIFO is not ready even if it pops in the same cycle (no bypass).
- Arbitration is combinational over FIFO non-empty flags.
  - Grant = first non-empty index scanning from pointer ptr upward, wrapping mod UNITS.
  - On grant g: pop FIFO g; register its head into the broadcast outputs; ptr <= (g+1) mod UNITS.
  - No grant: operand_valid <= 0; tag/value registers hold.
- Bus has no back-pressure; every broadcast is consumed by all listeners.
- Simultaneous push and pop on a non-full FIFO: both occur; count unchanged; ordering preserved.
- Per-unit order preserved (FIFO). No ordering guarantee across units beyond round-robin.
- Reset: all FIFOs emptied, count = 0, ptr = 0, operand_valid = 0, update_op_rs_id = 0, update_op_value = 0. Hence result_ready = all ones from the first cycle after reset. Reset mid-operation discards all buffered results; in-flight handshakes on the reset edge are dropped.
- Tag values are passed through unchanged; no tag is reserved.

## Timing
- Latency: result accepted at edge k → earliest broadcast visible after edge k+1 (operand_valid high during cycle k+1..k+2).
- Throughput: 1 broadcast/cycle total. A unit pushing every cycle gets ≥1 slot every UNITS cycles.
- Starvation bound: a non-empty FIFO is granted within UNITS cycles.
- Pointer wrap: ptr = UNITS-1 with grant UNITS-1 → ptr = 0.
- FIFO pointers use $clog2(BUFFER_DEPTH) bits and wrap naturally; count uses $clog2(BUFFER_DEPTH)+1 bits.

## Structure
- ppc_types gains result_bus_t (packed: rs_id [0:RS_ID_WIDTH-1] at width 5, value [0:31]). Use it for FIFO entries and the broadcast register.
- Sub-module result_fifo (DEPTH, entry type parameterised). Synchronous FIFO with push/pop/full/empty/count, instantiated UNITS times.
- Arbiter and broadcast register live in result_bus_arbiter itself.

## Test plan
- Reset: after rst, check result_ready = 4'b1111, operand_valid = 0, update_op_rs_id = 0, update_op_value = 0.
- Single result: unit 2 pushes (rs_id 5, value 16) at edge k → operand_valid = 1 exactly one cycle after edge k+1 with tag 5, value 16; then 0.
- Contention: all four units push at the same edge with tags 1..4 and values 10..13 → broadcasts in order tag 1,2,3,4 on consecutive cycles; ptr ends at 0.
- Fairness: unit 0 pushes continuously while unit 3 pushes once → unit 3 broadcast within ≤4 cycles; unit 0 order preserved.
- Full FIFO: drive unit 1 with 3 pushes while others also hold results so unit 1 is not drained → result_ready[1] falls after 2 entries; the third value is accepted only after a pop; all three broadcast in push order.
- Reset mid-flight: fill two FIFOs, assert rst for one cycle → no further broadcasts, all ready high, ptr = 0.

Source files
------------

// File: rtl/result_bus_arbiter_pkg.sv
// result_bus_arbiter_pkg
// Shared types and helpers for the result broadcast bus.
//   result_bus_t : one (rs_id, value) pair as carried by the unit FIFOs
//                  and by the registered broadcast port.
//   wrap_index   : (base + offset) mod modulus, used by the round-robin scan.
package result_bus_arbiter_pkg;

  localparam int RB_RS_ID_WIDTH = 5;
  localparam int RB_VALUE_WIDTH = 32;

  typedef struct packed {
    logic [0:RB_RS_ID_WIDTH-1] rs_id;
    logic [0:RB_VALUE_WIDTH-1] value;
  } result_bus_t;

  function automatic int wrap_index(input int base, input int offset, input int modulus);
    return (base + offset) % modulus;
  endfunction

endpackage

// File: rtl/result_bus_arbiter_if.sv
// result_bus_arbiter_if
// Bundles the unit-side ready/valid result handshakes and the broadcast
// operand-update bus.
//   result_valid/ready/rs_id/value : one ready-valid channel per unit
//   operand_valid/update_op_*      : registered broadcast, valid-only
// Modports: master = units + listeners (testbench side), slave = arbiter.
interface result_bus_arbiter_if #(
  parameter int UNITS       = 4,
  parameter int RS_ID_WIDTH = 5
);

  logic [0:UNITS-1]       result_valid;
  logic [0:UNITS-1]       result_ready;
  logic [0:RS_ID_WIDTH-1] result_rs_id [UNITS];
  logic [0:31]            result_value [UNITS];

  logic                   operand_valid;
  logic [0:RS_ID_WIDTH-1] update_op_rs_id;
  logic [0:31]            update_op_value;

  modport master (
    output result_valid, result_rs_id, result_value,
    input  result_ready, operand_valid, update_op_rs_id, update_op_value
  );

  modport slave (
    input  result_valid, result_rs_id, result_value,
    output result_ready, operand_valid, update_op_rs_id, update_op_value
  );

endinterface

// File: rtl/result_bus_arbiter_fifo.sv
// result_fifo
// Small synchronous FIFO holding completed results for one unit.
//   clk, rst      : clock, synchronous active-high reset (empties FIFO)
//   push, wdata   : write request and entry (ignored when full)
//   pop, rdata    : read request (ignored when empty) and current head
//   full, empty   : status from the registered count
//   count         : number of stored entries (0..DEPTH)
module result_fifo
  import result_bus_arbiter_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = result_bus_t,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  T              wdata,
  input  logic          pop,
  output T              rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  T              mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointers are exactly PW bits wide because DEPTH is a power of two,
  // so they wrap on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/result_bus_arbiter.sv
// result_bus_arbiter
// Buffers results from UNITS execution units in per-unit FIFOs and drains
// them round-robin, one per cycle, onto the registered operand-update bus
// that every reservation station snoops.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of result_bus_arbiter_if (unit handshakes in,
//              ready and broadcast out)
module result_bus_arbiter
  import result_bus_arbiter_pkg::*;
#(
  parameter int UNITS        = 4,
  parameter int RS_ID_WIDTH  = RB_RS_ID_WIDTH,
  parameter int BUFFER_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  result_bus_arbiter_if.slave  bus
);

  localparam int PTR_W = $clog2(UNITS);
  localparam int CW    = $clog2(BUFFER_DEPTH) + 1;

  logic [0:UNITS-1] fifo_push;
  logic [0:UNITS-1] fifo_pop;
  logic [0:UNITS-1] fifo_full;
  logic [0:UNITS-1] fifo_empty;
  logic [CW-1:0]    fifo_count [UNITS];
  result_bus_t      fifo_wdata [UNITS];
  result_bus_t      fifo_head  [UNITS];

  logic             grant_valid;
  logic [PTR_W-1:0] grant_idx;
  logic [PTR_W-1:0] next_ptr;
  logic [PTR_W-1:0] ptr;
  result_bus_t      bcast;
  logic             bcast_valid;

  for (genvar i = 0; i < UNITS; i++) begin : g_unit
    // Ready comes from the registered count only, so a full FIFO stays
    // not-ready in the cycle it is popped.
    assign bus.result_ready[i] = (fifo_count[i] != CW'(BUFFER_DEPTH));
    assign fifo_push[i]        = bus.result_valid[i] && !fifo_full[i];
    assign fifo_pop[i]         = grant_valid && (grant_idx == PTR_W'(i));
    assign fifo_wdata[i]       = '{rs_id: bus.result_rs_id[i], value: bus.result_value[i]};

    result_fifo #(
      .DEPTH (BUFFER_DEPTH),
      .T     (result_bus_t)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push[i]),
      .wdata (fifo_wdata[i]),
      .pop   (fifo_pop[i]),
      .rdata (fifo_head[i]),
      .full  (fifo_full[i]),
      .empty (fifo_empty[i]),
      .count (fifo_count[i])
    );
  end

  // Round-robin scan: first non-empty FIFO at or after ptr, wrapping.
  always_comb begin : grant_scan
    int idx;
    idx         = 0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < UNITS; k++) begin
      idx = wrap_index(int'(ptr), k, UNITS);
      if (!grant_valid && !fifo_empty[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx[PTR_W-1:0];
      end
    end
  end

  // Explicit wrap so non-power-of-two UNITS also cycles correctly.
  assign next_ptr = (grant_idx == PTR_W'(UNITS - 1)) ? '0 : grant_idx + 1'b1;

  // Broadcast register: tag/value hold when nothing is granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcast_valid <= 1'b0;
      bcast       <= '0;
      ptr         <= '0;
    end else begin
      bcast_valid <= grant_valid;
      if (grant_valid) begin
        bcast <= fifo_head[grant_idx];
        ptr   <= next_ptr;
      end
    end
  end

  assign bus.operand_valid   = bcast_valid;
  assign bus.update_op_rs_id = bcast.rs_id;
  assign bus.update_op_value = bcast.value;

endmodule

// File: tb/tb_result_bus_arbiter.sv
// tb_result_bus_arbiter
// Directed self-checking bench for result_bus_arbiter (UNITS=4,
// RS_ID_WIDTH=5, BUFFER_DEPTH=2). Inputs change and outputs are sampled
// 1 ns after each rising edge; expected values are hand-derived.
module tb_result_bus_arbiter;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  result_bus_arbiter_if #(.UNITS(4), .RS_ID_WIDTH(5)) bus_if ();

  result_bus_arbiter #(
    .UNITS        (4),
    .RS_ID_WIDTH  (5),
    .BUFFER_DEPTH (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int unit, input logic valid,
                               input logic [4:0] tag, input logic [31:0] value);
    bus_if.result_valid[unit] = valid;
    bus_if.result_rs_id[unit] = tag;
    bus_if.result_value[unit] = value;
  endtask

  task automatic clearInputs();
    for (int u = 0; u < 4; u++) applyStimulus(u, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic compare(input string name, input logic [31:0] observed,
                         input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", name, observed, expected);
    end
  endtask

  // Tag/value are only meaningful when a broadcast is expected.
  task automatic checkOutput(input string name, input logic exp_valid,
                             input logic [4:0] exp_tag, input logic [31:0] exp_value);
    compare({name, ".valid"}, {31'd0, bus_if.operand_valid}, {31'd0, exp_valid});
    if (exp_valid) begin
      compare({name, ".tag"}, {27'd0, bus_if.update_op_rs_id}, {27'd0, exp_tag});
      compare({name, ".value"}, bus_if.update_op_value, exp_value);
    end
  endtask

  task automatic checkReady(input string name, input logic [0:3] exp_ready);
    compare({name, ".ready"}, {28'd0, bus_if.result_ready}, {28'd0, exp_ready});
  endtask

  task automatic checkPtr(input string name, input logic [1:0] exp_ptr);
    compare({name, ".ptr"}, {30'd0, dut.ptr}, {30'd0, exp_ptr});
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    clearInputs();
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    checkReady("reset", 4'b1111);
    compare("reset.valid", {31'd0, bus_if.operand_valid}, 32'd0);
    compare("reset.tag", {27'd0, bus_if.update_op_rs_id}, 32'd0);
    compare("reset.value", bus_if.update_op_value, 32'd0);
    checkPtr("reset", 2'd0);

    // Single result from unit 2: visible one edge after acceptance
    applyStimulus(2, 1'b1, 5'd5, 32'd16);
    tick();
    clearInputs();
    checkOutput("single_accept", 1'b0, 5'd0, 32'd0);
    tick();
    checkOutput("single_bcast", 1'b1, 5'd5, 32'd16);
    tick();
    checkOutput("single_after", 1'b0, 5'd0, 32'd0);
    compare("single_hold.tag", {27'd0, bus_if.update_op_rs_id}, 32'd5);
    checkPtr("single", 2'd3);

    // Contention from ptr=0: all four push together
    pulseReset();
    for (int u = 0; u < 4; u++) applyStimulus(u, 1'b1, 5'(u + 1), 32'(10 + u));
    tick();
    clearInputs();
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput($sformatf("contention_%0d", k), 1'b1, 5'(k + 1), 32'(10 + k));
    end
    tick();
    checkOutput("contention_idle", 1'b0, 5'd0, 32'd0);
    checkPtr("contention", 2'd0);

    // Fairness: unit 0 keeps pushing, unit 3 pushes once
    applyStimulus(0, 1'b1, 5'd7, 32'd100);
    applyStimulus(3, 1'b1, 5'd9, 32'd200);
    tick();
    applyStimulus(3, 1'b0, 5'd0, 32'd0);
    applyStimulus(0, 1'b1, 5'd7, 32'd101);
    tick();
    checkOutput("fair_e1", 1'b1, 5'd7, 32'd100);
    applyStimulus(0, 1'b1, 5'd7, 32'd102);
    tick();
    checkOutput("fair_unit3", 1'b1, 5'd9, 32'd200);
    applyStimulus(0, 1'b0, 5'd0, 32'd0);
    tick();
    checkOutput("fair_e3", 1'b1, 5'd7, 32'd101);
    tick();
    checkOutput("fair_e4", 1'b1, 5'd7, 32'd102);
    tick();
    checkOutput("fair_idle", 1'b0, 5'd0, 32'd0);

    // Full FIFO on unit 1 while the other units hold results
    pulseReset();
    applyStimulus(0, 1'b1, 5'd20, 32'd300);
    applyStimulus(1, 1'b1, 5'd11, 32'd500);
    applyStimulus(2, 1'b1, 5'd21, 32'd301);
    applyStimulus(3, 1'b1, 5'd22, 32'd302);
    tick();
    clearInputs();
    applyStimulus(1, 1'b1, 5'd12, 32'd501);
    tick();
    checkOutput("full_e1", 1'b1, 5'd20, 32'd300);
    checkReady("full_e1", 4'b1011);
    applyStimulus(1, 1'b1, 5'd13, 32'd502);
    tick();
    checkOutput("full_e2", 1'b1, 5'd11, 32'd500);
    checkReady("full_e2", 4'b1111);
    tick();
    checkOutput("full_e3", 1'b1, 5'd21, 32'd301);
    checkReady("full_e3", 4'b1011);
    applyStimulus(1, 1'b0, 5'd0, 32'd0);
    tick();
    checkOutput("full_e4", 1'b1, 5'd22, 32'd302);
    tick();
    checkOutput("full_e5", 1'b1, 5'd12, 32'd501);
    tick();
    checkOutput("full_e6", 1'b1, 5'd13, 32'd502);
    tick();
    checkOutput("full_idle", 1'b0, 5'd0, 32'd0);

    // Reset mid-flight with two FIFOs holding results and handshakes in flight
    applyStimulus(0, 1'b1, 5'd1, 32'h11);
    applyStimulus(1, 1'b1, 5'd2, 32'h22);
    tick();
    applyStimulus(0, 1'b1, 5'd3, 32'h33);
    applyStimulus(1, 1'b1, 5'd4, 32'h44);
    tick();
    checkOutput("midrst_pre", 1'b1, 5'd1, 32'h11);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clearInputs();
    compare("midrst.valid", {31'd0, bus_if.operand_valid}, 32'd0);
    compare("midrst.tag", {27'd0, bus_if.update_op_rs_id}, 32'd0);
    compare("midrst.value", bus_if.update_op_value, 32'd0);
    checkReady("midrst", 4'b1111);
    checkPtr("midrst", 2'd0);
    tick();
    checkOutput("midrst_idle1", 1'b0, 5'd0, 32'd0);
    tick();
    checkOutput("midrst_idle2", 1'b0, 5'd0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
